bus_responder_mux: RTL and testbench



---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_sync2.sv | 27 ++
 rtl/bus_responder_mux.sv | 145 ++++++++++++++
 tb/tb_bus_responder_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the multiplexed AS/DS/RW/AD bus responder.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ACK,
    ERR,
    IGNORE
  } state_t;

  localparam logic ASSERT_L = 1'b0;
  localparam logic NEGATE_L = 1'b1;

  // DSACK1/DSACK0 pair; both asserted means a 32-bit port terminated the cycle.
  typedef struct packed {
    logic dsack1;
    logic dsack0;
  } dsack_t;

  localparam dsack_t DSACK_32   = '{dsack1: ASSERT_L, dsack0: ASSERT_L};
  localparam dsack_t DSACK_NONE = '{dsack1: NEGATE_L, dsack0: NEGATE_L};

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bus_sync2.sv
// Parameterised-width two-flop synchronizer with a selectable reset value.
module bus_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bus_responder_mux.sv
// Bus target: decodes an address window, serves reads/writes from a small word
// memory and terminates each cycle with DSACK (32-bit port) or BERR.
module bus_responder_mux
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h20200000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF0000,
  parameter int          MEM_AW      = 6,
  parameter int          WAIT_STATES = 2
) (
  input  logic        pin_clk_16M,
  input  logic        pin_reset,
  input  logic        pin_as,
  input  logic        pin_ds,
  input  logic        pin_rw,
  input  logic [31:0] pin_ad_in,
  output logic [31:0] pin_ad_out,
  output logic        pin_ad_oe,
  output logic        pin_dsack0,
  output logic        pin_dsack1,
  output logic        pin_berr,
  output logic [15:0] cycle_count
);

  logic [2:0]  w_strb_s;
  logic [31:0] w_ad_s;
  logic        w_as_s;
  logic        w_ds_s;
  logic        w_rw_s;

  // Strobes idle negated (and RW idles as read) while the synchronizers reset.
  bus_sync2 #(.W(3), .RST_VAL(3'b111)) u_sync_strb (
    .i_clk  (pin_clk_16M),
    .i_srst (pin_reset),
    .i_d    ({pin_as, pin_ds, pin_rw}),
    .o_q    (w_strb_s)
  );

  bus_sync2 #(.W(32), .RST_VAL(32'h0)) u_sync_ad (
    .i_clk  (pin_clk_16M),
    .i_srst (pin_reset),
    .i_d    (pin_ad_in),
    .o_q    (w_ad_s)
  );

  assign w_as_s = w_strb_s[2];
  assign w_ds_s = w_strb_s[1];
  assign w_rw_s = w_strb_s[0];

  state_t            r_state;
  state_t            w_state_next;
  logic [MEM_AW-1:0] r_index;
  logic              r_rw;
  logic [3:0]        r_cnt;
  logic [31:0]       r_ad_out;
  logic              r_oe;
  dsack_t            r_dsack;
  logic              r_berr;
  logic [15:0]       r_cycle_count;
  logic [31:0]       r_mem [0:(2**MEM_AW)-1];

  logic w_hit;
  logic w_commit;
  logic w_done;

  assign w_hit = addr_hit(w_ad_s, BASE_ADDR, ADDR_MASK);

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_as_s == ASSERT_L) begin
          if (!w_hit)                   w_state_next = IGNORE;
          else if (w_ad_s[1:0] != 2'b00) w_state_next = ERR;
          else                          w_state_next = ADDR;
        end
      end
      ADDR: begin
        if (w_as_s == NEGATE_L)      w_state_next = IDLE;
        else if (w_ds_s == ASSERT_L) w_state_next = WAIT;
      end
      WAIT: begin
        // An aborting master wins over a commit landing on the same edge.
        if (w_as_s == NEGATE_L) begin
          w_state_next = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_next = ACK;
          w_commit     = 1'b1;
        end
      end
      ACK: begin
        if (w_as_s == NEGATE_L) begin
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
      end
      ERR, IGNORE: begin
        if (w_as_s == NEGATE_L) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pin_clk_16M) begin
    if (pin_reset) begin
      r_state       <= IDLE;
      r_index       <= '0;
      r_rw          <= 1'b1;
      r_cnt         <= 4'd0;
      r_ad_out      <= 32'h0;
      r_oe          <= 1'b0;
      r_dsack       <= DSACK_NONE;
      r_berr        <= NEGATE_L;
      r_cycle_count <= 16'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next != IDLE) begin
        r_index <= w_ad_s[MEM_AW+1:2];
        r_rw    <= w_rw_s;
      end
      if (r_state == ADDR && w_state_next == WAIT) r_cnt <= 4'(WAIT_STATES);
      else if (r_state == WAIT)                    r_cnt <= r_cnt - 4'd1;
      if (w_commit && r_rw) r_ad_out <= r_mem[r_index];
      // Outputs follow the next state so they change on the same edge as it.
      r_oe    <= (w_state_next == ACK) && r_rw;
      r_dsack <= (w_state_next == ACK) ? DSACK_32 : DSACK_NONE;
      r_berr  <= (w_state_next == ERR) ? ASSERT_L : NEGATE_L;
      if (w_done) r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  always_ff @(posedge pin_clk_16M) begin
    if (!pin_reset && w_commit && !r_rw) r_mem[r_index] <= w_ad_s;
  end

  assign pin_ad_out  = r_ad_out;
  assign pin_ad_oe   = r_oe;
  assign pin_dsack0  = r_dsack.dsack0;
  assign pin_dsack1  = r_dsack.dsack1;
  assign pin_berr    = r_berr;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_bus_responder_mux.sv
// Scoreboard bench for bus_responder_mux: directed bus cycles queue expected
// terminations, a negedge monitor pops and compares them as they appear.
module tb_bus_responder_mux;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n;
  logic        ds_n;
  logic        rw;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        dsack0;
  logic        dsack1;
  logic        berr;
  logic [15:0] cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          is_berr;
    bit          is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   prev_dsack = 1'b1;
  bit   prev_berr  = 1'b1;

  bus_responder_mux #(
    .BASE_ADDR   (32'h20200000),
    .ADDR_MASK   (32'hFFFF0000),
    .MEM_AW      (6),
    .WAIT_STATES (WS)
  ) dut (
    .pin_clk_16M (clk),
    .pin_reset   (rst),
    .pin_as      (as_n),
    .pin_ds      (ds_n),
    .pin_rw      (rw),
    .pin_ad_in   (ad_in),
    .pin_ad_out  (ad_out),
    .pin_ad_oe   (ad_oe),
    .pin_dsack0  (dsack0),
    .pin_dsack1  (dsack1),
    .pin_berr    (berr),
    .cycle_count (cnt)
  );

  always #31 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Monitor: every falling DSACK or BERR is one terminated cycle.
  always @(negedge clk) begin
    if (prev_dsack && !dsack0) begin
      if (q.size() == 0) begin
        check("unexpected_dsack", 32'(dsack0), 32'd1);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_kind_dsack"}, 32'(mon_e.is_berr), 32'd0);
        check({mon_e.name, "_dsack1"}, 32'(dsack1), 32'd0);
        check({mon_e.name, "_oe"}, 32'(ad_oe), 32'(mon_e.is_read));
        if (mon_e.is_read) check({mon_e.name, "_data"}, ad_out, mon_e.data);
      end
    end
    if (prev_berr && !berr) begin
      if (q.size() == 0) begin
        check("unexpected_berr", 32'(berr), 32'd1);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_kind_berr"}, 32'(mon_e.is_berr), 32'd1);
        check({mon_e.name, "_berr_oe"}, 32'(ad_oe), 32'd0);
      end
    end
    prev_dsack = dsack0;
    prev_berr  = berr;
  end

  function automatic void expect_cycle(bit b, bit r, logic [31:0] d, string name);
    exp_t e;
    e.is_berr = b;
    e.is_read = r;
    e.data    = d;
    e.name    = name;
    q.push_back(e);
  endfunction

  // One bus cycle: address phase, DS three clocks later, then either wait for a
  // termination (bounded) or abort by negating AS one clock after DS is seen.
  task automatic bus_cycle(input logic [31:0] a, input logic r, input logic [31:0] wd,
                           input bit abort, output int lat, output bit resp);
    int n;
    resp = 1'b0;
    lat  = -1;
    n    = 0;
    @(negedge clk);
    as_n = 1'b0; rw = r; ad_in = a;
    repeat (3) @(negedge clk);
    ds_n = 1'b0;
    if (!r) ad_in = wd;
    if (abort) begin
      repeat (2) @(negedge clk);
      as_n = 1'b1; ds_n = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (!dsack0 || !dsack1 || !berr || ad_oe) resp = 1'b1;
      end
    end else begin
      while (n < 16 && !resp) begin
        @(negedge clk);
        n++;
        if (!dsack0 || !berr) begin
          resp = 1'b1;
          lat  = n - 1;
        end
        if (ad_oe && !resp) resp = 1'b1;
      end
      @(negedge clk);
      as_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  resp;
    int  n;
    rst = 1'b1; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; ad_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_dsack0", 32'(dsack0), 32'd1);
    check("rst_dsack1", 32'(dsack1), 32'd1);
    check("rst_berr",   32'(berr),   32'd1);
    check("rst_oe",     32'(ad_oe),  32'd0);
    check("rst_ad_out", ad_out,      32'h0);
    check("rst_count",  32'(cnt),    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    expect_cycle(1'b0, 1'b0, 32'h0, "wr_10");
    bus_cycle(32'h20200010, 1'b0, 32'hDEADBEEF, 1'b0, lat, resp);
    check("wr_10_latency", 32'(lat), 32'(2 + WS));
    check("wr_10_released", 32'(dsack0), 32'd1);
    check("wr_10_count", 32'(cnt), 32'd1);

    expect_cycle(1'b0, 1'b1, 32'hDEADBEEF, "rd_10");
    bus_cycle(32'h20200010, 1'b1, 32'h0, 1'b0, lat, resp);
    check("rd_10_oe_released", 32'(ad_oe), 32'd0);
    check("rd_10_count", 32'(cnt), 32'd2);

    bus_cycle(32'h12345678, 1'b1, 32'h0, 1'b0, lat, resp);
    check("miss_no_response", 32'(resp), 32'd0);
    check("miss_count", 32'(cnt), 32'd2);

    expect_cycle(1'b1, 1'b1, 32'h0, "misaligned_12");
    bus_cycle(32'h20200012, 1'b1, 32'h0, 1'b0, lat, resp);
    check("misaligned_berr_released", 32'(berr), 32'd1);
    check("misaligned_count", 32'(cnt), 32'd2);

    expect_cycle(1'b0, 1'b1, 32'hDEADBEEF, "rd_10_after_err");
    bus_cycle(32'h20200010, 1'b1, 32'h0, 1'b0, lat, resp);
    check("rd_10_after_err_count", 32'(cnt), 32'd3);

    expect_cycle(1'b0, 1'b0, 32'h0, "wr_20");
    bus_cycle(32'h20200020, 1'b0, 32'hCAFEF00D, 1'b0, lat, resp);
    check("wr_20_count", 32'(cnt), 32'd4);

    bus_cycle(32'h20200020, 1'b0, 32'h12345678, 1'b1, lat, resp);
    check("abort_no_response", 32'(resp), 32'd0);
    check("abort_count", 32'(cnt), 32'd4);

    expect_cycle(1'b0, 1'b1, 32'hCAFEF00D, "rd_20_after_abort");
    bus_cycle(32'h20200020, 1'b1, 32'h0, 1'b0, lat, resp);
    check("rd_20_after_abort_count", 32'(cnt), 32'd5);

    // Reset while the read is being acknowledged.
    expect_cycle(1'b0, 1'b1, 32'hDEADBEEF, "rd_10_reset");
    @(negedge clk);
    as_n = 1'b0; rw = 1'b1; ad_in = 32'h20200010;
    repeat (3) @(negedge clk);
    ds_n = 1'b0;
    n = 0;
    while (n < 16 && dsack0) begin
      @(negedge clk);
      n++;
    end
    check("rd_10_reset_reached_ack", 32'(dsack0), 32'd0);
    rst = 1'b1; as_n = 1'b1; ds_n = 1'b1;
    @(negedge clk);
    check("reset_mid_dsack0", 32'(dsack0), 32'd1);
    check("reset_mid_dsack1", 32'(dsack1), 32'd1);
    check("reset_mid_oe", 32'(ad_oe), 32'd0);
    check("reset_mid_count", 32'(cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    expect_cycle(1'b0, 1'b1, 32'hDEADBEEF, "rd_10_post_reset");
    bus_cycle(32'h20200010, 1'b1, 32'h0, 1'b0, lat, resp);
    expect_cycle(1'b0, 1'b1, 32'hCAFEF00D, "rd_20_post_reset");
    bus_cycle(32'h20200020, 1'b1, 32'h0, 1'b0, lat, resp);
    check("post_reset_count", 32'(cnt), 32'd2);

    @(negedge clk);
    force dut.r_cycle_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_cycle_count;
    @(negedge clk);
    check("preload_count", 32'(cnt), 32'h0000FFFF);
    expect_cycle(1'b0, 1'b0, 32'h0, "wr_30_wrap");
    bus_cycle(32'h20200030, 1'b0, 32'h0BADF00D, 1'b0, lat, resp);
    check("wrap_count", 32'(cnt), 32'h0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
